// File: rtl/mul_div_pkg.sv
// Shared encodings for the ALU family: ALU operation codes, the
// multiply/divide op select and the multiply/divide FSM states.
package mul_div_pkg;

    // ALU operation constants used by the surrounding datapath
    localparam logic [3:0] ALU_ADD  = 4'h0;
    localparam logic [3:0] ALU_SUB  = 4'h1;
    localparam logic [3:0] ALU_AND  = 4'h2;
    localparam logic [3:0] ALU_OR   = 4'h3;
    localparam logic [3:0] ALU_XOR  = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h5;
    localparam logic [3:0] ALU_SRL  = 4'h6;
    localparam logic [3:0] ALU_MULD = 4'h7;

    // Operation select of the sequential multiply/divide unit
    typedef enum logic {
        MD_MUL  = 1'b0,
        MD_DIVU = 1'b1
    } md_op_e;

    // Multiply/divide controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } md_state_e;

endpackage

// File: rtl/md_step.sv
// One iteration of the multiply/divide datapath, purely combinational.
// acc holds {hi, lo}: for MUL hi is the running partial product and lo the
// remaining multiplier bits; for DIVU hi is the partial remainder and lo the
// dividend bits still to shift in, with quotient bits entering at the bottom.
module md_step
    import mul_div_pkg::*;
#(
    parameter int W = 32
) (
    input  md_op_e           op_i,
    input  logic [W-1:0]     opnd_i,
    input  logic [2*W-1:0]   acc_i,
    output logic [2*W-1:0]   acc_o
);

    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W:0]   addend;
    logic [W:0]   sum;
    logic [W:0]   part;
    logic [W:0]   diff;
    logic         ge;

    // Shift-and-add for MUL, restoring subtract-and-shift for DIVU
    always_comb begin
        hi     = acc_i[2*W-1:W];
        lo     = acc_i[W-1:0];
        addend = lo[0] ? {1'b0, opnd_i} : '0;
        sum    = {1'b0, hi} + addend;
        // Partial remainder needs W+1 bits before the trial subtraction
        part   = {hi, lo[W-1]};
        diff   = part - {1'b0, opnd_i};
        // part < 2*divisor, so the top bit of diff is exactly the borrow
        ge     = ~diff[W];
        if (op_i == MD_MUL) begin
            acc_o = {sum, lo[W-1:1]};
        end else begin
            acc_o = {(ge ? diff[W-1:0] : part[W-1:0]), lo[W-2:0], ge};
        end
    end

endmodule

// File: rtl/mul_div_seq.sv
// Sequential unsigned multiplier / restoring divider with valid/ready
// handshakes on both request and result sides. One bit per cycle, BITSIZE
// cycles per operation; divide by zero short-circuits straight to DONE.
module mul_div_seq
    import mul_div_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               rstn_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic               op_i,
    input  logic [BITSIZE-1:0] A_i,
    input  logic [BITSIZE-1:0] B_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [BITSIZE-1:0] R_o,
    output logic [BITSIZE-1:0] H_o,
    output logic               div_zero_o
);

    localparam int CNT_W = $clog2(BITSIZE) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BITSIZE - 1);

    md_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*BITSIZE-1:0] acc_q, acc_d;
    md_op_e               op_q, op_d;
    logic [BITSIZE-1:0]   opnd_q, opnd_d;
    logic [BITSIZE-1:0]   r_q, r_d;
    logic [BITSIZE-1:0]   h_q, h_d;
    logic                 dz_q, dz_d;
    logic [2*BITSIZE-1:0] step_acc;
    md_op_e               req_op;

    assign req_op = md_op_e'(op_i);

    md_step #(.W(BITSIZE)) u_step (
        .op_i   (op_q),
        .opnd_i (opnd_q),
        .acc_i  (acc_q),
        .acc_o  (step_acc)
    );

    // Handshake flags depend on state only, never on the incoming valid/ready
    assign ready_o    = (state_q == IDLE);
    assign valid_o    = (state_q == DONE);
    assign R_o        = r_q;
    assign H_o        = h_q;
    assign div_zero_o = dz_q;

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        op_d    = op_q;
        opnd_d  = opnd_q;
        r_d     = r_q;
        h_d     = h_q;
        dz_d    = dz_q;
        case (state_q)
            IDLE: begin
                if (valid_i) begin
                    op_d  = req_op;
                    cnt_d = '0;
                    // The accumulator low half holds the operand consumed bit by bit
                    if (req_op == MD_MUL) begin
                        acc_d  = {{BITSIZE{1'b0}}, B_i};
                        opnd_d = A_i;
                    end else begin
                        acc_d  = {{BITSIZE{1'b0}}, A_i};
                        opnd_d = B_i;
                    end
                    if (req_op == MD_DIVU && B_i == '0) begin
                        state_d = DONE;
                        r_d     = '1;
                        h_d     = A_i;
                        dz_d    = 1'b1;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = step_acc;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = DONE;
                    r_d     = step_acc[BITSIZE-1:0];
                    h_d     = step_acc[2*BITSIZE-1:BITSIZE];
                    dz_d    = 1'b0;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by reset
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            op_q    <= MD_MUL;
            opnd_q  <= '0;
            r_q     <= '0;
            h_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            opnd_q  <= opnd_d;
            r_q     <= r_d;
            h_q     <= h_d;
            dz_q    <= dz_d;
        end
    end

endmodule
